// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the I/D cache to single memory port arbiter.
package mem_arbiter_pkg;
  localparam int          LINE_W_DEF = 64;
  localparam logic [31:0] ZERO_WORD  = 32'h0;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbBusy    = 2'd1,
    ArbRelease = 2'd2
  } arb_state_t;

  typedef enum logic {
    GrantIf  = 1'b0,
    GrantMem = 1'b1
  } grant_t;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache onto one memory port; `ARB_ROUND_ROBIN_EN selects alternating ties, else D-cache wins.
// ms_req_o rises one cycle after a request; reply is routed back the same cycle; requesters hold req until their reply.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_rep_o,
  output logic [LINE_W-1:0] if_rep_data_o,
  input  logic              mem_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_write_data_i,
  input  logic [3:0]        mem_write_mask_i,
  output logic              mem_rep_o,
  output logic [LINE_W-1:0] mem_rep_data_o,
  output logic              ms_req_o,
  output logic [ADDR_W-1:0] ms_addr_o,
  output logic              ms_write_o,
  output logic [31:0]       ms_write_data_o,
  output logic [3:0]        ms_write_mask_o,
  input  logic              ms_rep_i,
  input  logic [LINE_W-1:0] ms_rep_data_i
);

  arb_state_t state;
  grant_t     grant;
  grant_t     win;
  logic       win_vld;
  logic       rep_hit;

  // grant doubles as the last-grant pointer; it resets to IF so the first tie favours MEM.
  always_comb begin
    win_vld = if_req_i | mem_req_i;
    win     = GrantMem;
    if (if_req_i && !mem_req_i) begin
      win = GrantIf;
    end else if (if_req_i && mem_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = (grant == GrantIf) ? GrantMem : GrantIf;
`else
      win = GrantMem;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ArbIdle;
      grant           <= GrantIf;
      ms_req_o        <= 1'b0;
      ms_addr_o       <= '0;
      ms_write_o      <= 1'b0;
      ms_write_data_o <= ZERO_WORD;
      ms_write_mask_o <= 4'h0;
    end else begin
      case (state)
        ArbIdle: begin
          if (win_vld) begin
            state    <= ArbBusy;
            grant    <= win;
            ms_req_o <= 1'b1;
            if (win == GrantMem) begin
              ms_addr_o       <= mem_addr_i;
              ms_write_o      <= mem_write_i;
              ms_write_data_o <= mem_write_data_i;
              ms_write_mask_o <= mem_write_mask_i;
            end else begin
              ms_addr_o       <= if_addr_i;
              ms_write_o      <= 1'b0;
              ms_write_data_o <= ZERO_WORD;
              ms_write_mask_o <= 4'h0;
            end
          end
        end
        ArbBusy: begin
          if (ms_rep_i) begin
            state           <= ArbRelease;
            ms_req_o        <= 1'b0;
            ms_addr_o       <= '0;
            ms_write_o      <= 1'b0;
            ms_write_data_o <= ZERO_WORD;
            ms_write_mask_o <= 4'h0;
          end
        end
        ArbRelease: state <= ArbIdle;
        default:    state <= ArbIdle;
      endcase
    end
  end

  // Replies outside BUSY (including while reset is held) are dropped.
  assign rep_hit        = (state == ArbBusy) && ms_rep_i && !rst;
  assign if_rep_o       = rep_hit && (grant == GrantIf);
  assign mem_rep_o      = rep_hit && (grant == GrantMem);
  assign if_rep_data_o  = if_rep_o  ? ms_rep_data_i : '0;
  assign mem_rep_data_o = mem_rep_o ? ms_rep_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory-port transactions queued at stimulus, checked at grant and reply.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 64;
  localparam bit SIDE_IF  = 1'b0;
  localparam bit SIDE_MEM = 1'b1;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_rep_o;
  logic [LINE_W-1:0] if_rep_data_o;
  logic              mem_req_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              mem_write_i;
  logic [31:0]       mem_write_data_i;
  logic [3:0]        mem_write_mask_i;
  logic              mem_rep_o;
  logic [LINE_W-1:0] mem_rep_data_o;
  logic              ms_req_o;
  logic [ADDR_W-1:0] ms_addr_o;
  logic              ms_write_o;
  logic [31:0]       ms_write_data_o;
  logic [3:0]        ms_write_mask_o;
  logic              ms_rep_i;
  logic [LINE_W-1:0] ms_rep_data_i;

  typedef struct packed {
    logic        side;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  mask;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rep_cyc = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rep_o(if_rep_o), .if_rep_data_o(if_rep_data_o),
    .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
    .mem_write_i(mem_write_i), .mem_write_data_i(mem_write_data_i),
    .mem_write_mask_i(mem_write_mask_i),
    .mem_rep_o(mem_rep_o), .mem_rep_data_o(mem_rep_data_o),
    .ms_req_o(ms_req_o), .ms_addr_o(ms_addr_o), .ms_write_o(ms_write_o),
    .ms_write_data_o(ms_write_data_o), .ms_write_mask_o(ms_write_mask_o),
    .ms_rep_i(ms_rep_i), .ms_rep_data_i(ms_rep_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ms_req"},   ms_req_o, 0);
    chk({tag, "_ms_addr"},  ms_addr_o, 0);
    chk({tag, "_ms_write"}, ms_write_o, 0);
    chk({tag, "_ms_wd"},    ms_write_data_o, 0);
    chk({tag, "_ms_mask"},  ms_write_mask_o, 0);
    chk({tag, "_if_rep"},   if_rep_o, 0);
    chk({tag, "_if_data"},  if_rep_data_o, 0);
    chk({tag, "_mem_rep"},  mem_rep_o, 0);
    chk({tag, "_mem_data"}, mem_rep_data_o, 0);
  endtask

  // Waits (bounded) for ms_req_o, pops the expected transaction and compares the port.
  task automatic wait_grant(output txn_t e, output int n);
    n = 0;
    e = '0;
    while (!ms_req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ms_req_wait", ms_req_o, 1);
    chk("exp_q_nonempty", exp_q.size() > 0, 1);
    if (ms_req_o && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ms_addr",  ms_addr_o, e.addr);
      chk("ms_write", ms_write_o, e.wr);
      chk("ms_wd",    ms_write_data_o, e.wd);
      chk("ms_mask",  ms_write_mask_o, e.mask);
    end
  endtask

  // Drives one reply in BUSY, checks routing, then checks RELEASE drops ms_req_o.
  task automatic reply(input logic [63:0] d, input txn_t e, input bit drop);
    ms_rep_i = 1'b1;
    ms_rep_data_i = d;
    #1;
    chk("if_rep",   if_rep_o, e.side == SIDE_IF);
    chk("if_data",  if_rep_data_o, (e.side == SIDE_IF) ? d : 64'h0);
    chk("mem_rep",  mem_rep_o, e.side == SIDE_MEM);
    chk("mem_data", mem_rep_data_o, (e.side == SIDE_MEM) ? d : 64'h0);
    @(posedge clk);
    rep_cyc = cyc;
    #1;
    ms_rep_i = 1'b0;
    ms_rep_data_i = '0;
    if (drop) begin
      if (e.side == SIDE_IF) if_req_i = 1'b0;
      else mem_req_i = 1'b0;
    end
    @(negedge clk);
    chk("release_ms_req", ms_req_o, 0);
    chk("release_if_rep", if_rep_o, 0);
  endtask

  task automatic push(input bit side, input logic [31:0] a, input bit wr,
                      input logic [31:0] wd, input logic [3:0] m);
    txn_t t;
    t.side = side; t.addr = a; t.wr = wr; t.wd = wd; t.mask = m;
    exp_q.push_back(t);
  endtask

  initial begin
    txn_t e;
    int   n;
    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0;
    mem_req_i = 0; mem_addr_i = '0; mem_write_i = 0;
    mem_write_data_i = '0; mem_write_mask_i = '0;
    ms_rep_i = 0; ms_rep_data_i = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", ms_req_o, 0);

    // IF read
    if_req_i = 1; if_addr_i = 32'h100;
    push(SIDE_IF, 32'h100, 0, 0, 0);
    wait_grant(e, n);
    chk("if_grant_latency", n, 1);
    reply(64'h1122334455667788, e, 1);

    // D-cache write
    @(negedge clk);
    mem_req_i = 1; mem_addr_i = 32'h2004; mem_write_i = 1;
    mem_write_data_i = 32'hDEADBEEF; mem_write_mask_i = 4'b0011;
    push(SIDE_MEM, 32'h2004, 1, 32'hDEADBEEF, 4'b0011);
    wait_grant(e, n);
    chk("mem_grant_latency", n, 1);
    reply(64'hCAFEF00D0BADBEEF, e, 1);
    mem_write_i = 0; mem_write_data_i = '0; mem_write_mask_i = '0;

    // Stray reply in IDLE is ignored
    @(negedge clk);
    ms_rep_i = 1; ms_rep_data_i = 64'hFFFF;
    #1;
    chk("stray_idle_if_rep", if_rep_o, 0);
    chk("stray_idle_mem_rep", mem_rep_o, 0);
    @(negedge clk);
    ms_rep_i = 0; ms_rep_data_i = '0;

    // Contention after fresh reset
    rst = 1; @(negedge clk); rst = 0;
    if_req_i = 1; if_addr_i = 32'h400;
    mem_req_i = 1; mem_addr_i = 32'h800;
`ifdef ARB_ROUND_ROBIN_EN
    push(SIDE_MEM, 32'h800, 0, 0, 0);
    push(SIDE_IF,  32'h400, 0, 0, 0);
    push(SIDE_MEM, 32'h800, 0, 0, 0);
`else
    push(SIDE_MEM, 32'h800, 0, 0, 0);
    push(SIDE_MEM, 32'h800, 0, 0, 0);
    push(SIDE_MEM, 32'h800, 0, 0, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      wait_grant(e, n);
      if (i > 0) chk("turnaround_ge2", (cyc - rep_cyc) >= 2, 1);
      reply(64'hA000 + 64'(i), e, i == 2);
    end
    if_req_i = 0; mem_req_i = 0;

    // Reset while BUSY
    @(negedge clk);
    mem_req_i = 1; mem_addr_i = 32'h500;
    push(SIDE_MEM, 32'h500, 0, 0, 0);
    wait_grant(e, n);
    rst = 1;
    #1;
    chk_idle_outputs("mid_rst");
    mem_req_i = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    ms_rep_i = 1; ms_rep_data_i = 64'h5555;
    #1;
    chk("post_rst_if_rep", if_rep_o, 0);
    chk("post_rst_mem_rep", mem_rep_o, 0);
    @(negedge clk);
    ms_rep_i = 0; ms_rep_data_i = '0;
    chk("post_rst_ms_req", ms_req_o, 0);

    // Request inputs change during BUSY
    if_req_i = 1; if_addr_i = 32'h300;
    push(SIDE_IF, 32'h300, 0, 0, 0);
    wait_grant(e, n);
    if_addr_i = 32'h999;
    mem_req_i = 1; mem_addr_i = 32'h2222; mem_write_i = 1;
    mem_write_data_i = 32'h12345678; mem_write_mask_i = 4'hF;
    repeat (2) @(negedge clk);
    chk("busy_hold_addr", ms_addr_o, 32'h300);
    chk("busy_hold_write", ms_write_o, 0);
    chk("busy_hold_req", ms_req_o, 1);
    mem_req_i = 0; mem_write_i = 0;
    reply(64'h0123456789ABCDEF, e, 1);
    @(negedge clk);
    chk("final_idle", ms_req_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
